// File: rtl/mover_2d_pkg.sv
// Shared definitions for the 2D mover: controller FSM encoding and default counter width.
package mover_2d_pkg;

    localparam int DEFAULT_TIMEOUT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/mover_2d_go_ctrl_if.sv
// CSR/core-facing bundle of the go/done controller; master drives requests, slave is the controller.
interface mover_2d_go_ctrl_if #(
    parameter int TIMEOUT_WIDTH = mover_2d_pkg::DEFAULT_TIMEOUT_WIDTH
);
    logic                     go_sync;
    logic                     irq_en;
    logic                     irq_clr;
    logic [TIMEOUT_WIDTH-1:0] timeout;
    logic                     core_done;
    logic                     core_start;
    logic                     busy;
    logic                     done;
    logic                     error;
    logic [TIMEOUT_WIDTH-1:0] cycle_count;
    logic                     irq;

    modport master (
        output go_sync, irq_en, irq_clr, timeout, core_done,
        input  core_start, busy, done, error, cycle_count, irq
    );

    modport slave (
        input  go_sync, irq_en, irq_clr, timeout, core_done,
        output core_start, busy, done, error, cycle_count, irq
    );
endinterface

// File: rtl/mover_2d_timer.sv
// Saturating BUSY-cycle counter with clear/enable; hit flags that the next count reaches a nonzero limit.
// Outputs are combinational from the registered count; no backpressure.
module mover_2d_timer #(
    parameter int WIDTH = mover_2d_pkg::DEFAULT_TIMEOUT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt_inc,
    output logic             hit
);
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + WIDTH'(1);
    // A zero limit disables the compare entirely.
    assign hit     = (limit != '0) && (cnt_inc == limit);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mover_2d_go_ctrl.sv
// Turns the synchronized go level into a one-cycle core_start, tracks the core until done or timeout,
// and returns a four-phase done level; outputs registered one cycle after the sampled event, irq is mask-gated.
module mover_2d_go_ctrl
    import mover_2d_pkg::*;
#(
    parameter int TIMEOUT_WIDTH = DEFAULT_TIMEOUT_WIDTH
) (
    input  logic               clk,
    input  logic               reset_n,
    mover_2d_go_ctrl_if.slave  bus
);
    state_e                   state_q, state_d;
    logic                     core_start_q, core_start_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     error_q, error_d;
    logic                     irq_pend_q, irq_pend_d;
    logic [TIMEOUT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                     done_entry;
    logic                     cnt_clr;
    logic                     cnt_en;
    logic                     tmr_hit;
    logic [TIMEOUT_WIDTH-1:0] cnt_inc;

    assign cnt_clr = (state_q == ST_START);
    assign cnt_en  = (state_q == ST_BUSY);

    mover_2d_timer #(
        .WIDTH (TIMEOUT_WIDTH)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .limit   (bus.timeout),
        .cnt_inc (cnt_inc),
        .hit     (tmr_hit)
    );

    always_comb begin
        state_d       = state_q;
        core_start_d  = 1'b0;
        busy_d        = busy_q;
        done_d        = done_q;
        error_d       = error_q;
        cycle_count_d = cycle_count_q;
        done_entry    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.go_sync) begin
                    state_d      = ST_START;
                    core_start_d = 1'b1;
                    busy_d       = 1'b1;
                    error_d      = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_BUSY;
                busy_d  = 1'b1;
            end
            ST_BUSY: begin
                // Completion outranks a timeout landing on the same cycle.
                if (bus.core_done || tmr_hit) begin
                    state_d       = ST_DONE;
                    done_entry    = 1'b1;
                    busy_d        = 1'b0;
                    done_d        = 1'b1;
                    error_d       = !bus.core_done;
                    cycle_count_d = cnt_inc;
                end
            end
            ST_DONE: begin
                if (!bus.go_sync) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (done_entry) begin
            irq_pend_d = 1'b1;
        end else if (bus.irq_clr) begin
            irq_pend_d = 1'b0;
        end else begin
            irq_pend_d = irq_pend_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            core_start_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            irq_pend_q    <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            core_start_q  <= core_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            irq_pend_q    <= irq_pend_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign bus.core_start  = core_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
    assign bus.cycle_count = cycle_count_q;
    assign bus.irq         = irq_pend_q & bus.irq_en;
endmodule

// File: tb/tb_mover_2d_go_ctrl.sv
// Directed bench for mover_2d_go_ctrl: table of complete operations plus hand-written corner sequences.
module tb_mover_2d_go_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mover_2d_go_ctrl_if #(.TIMEOUT_WIDTH(32)) bus ();

    mover_2d_go_ctrl #(.TIMEOUT_WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] timeout;
        int          dly;       // BUSY cycle carrying core_done, 0 = never
        logic        irq_en;
        int          exp_busy;  // cycles with busy=1, START included
        logic        exp_error;
        logic [31:0] exp_cc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [31:0] t, input int dly, input int clr_at,
                          output int starts, output int busy_n, output bit got);
        int s;
        s = -1; starts = 0; busy_n = 0; got = 1'b0;
        bus.timeout = t;
        bus.go_sync = 1'b1;
        for (int c = 0; c < 100 && !got; c++) begin
            tick();
            bus.core_done = 1'b0;
            bus.irq_clr   = 1'b0;
            if (bus.core_start) begin
                starts++;
                s = c;
            end
            if (bus.busy) busy_n++;
            if (bus.done) begin
                got = 1'b1;
            end else if (s >= 0) begin
                if (dly != 0 && c == s + dly) bus.core_done = 1'b1;
                if (clr_at != 0 && c == s + clr_at) bus.irq_clr = 1'b1;
            end
        end
        check("op_completes", 32'(got), 32'd1);
    endtask

    task automatic finish_op(input string tag);
        bus.go_sync = 1'b0;
        tick();
        check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        check({tag, "_irq_cleared"}, 32'(bus.irq), 32'd0);
        tick();
    endtask

    initial begin
        int starts, busy_n, n_start2, n_drop;
        bit got;

        vecs[0] = '{32'd0,  10, 1'b1, 11, 1'b0, 32'd10};
        vecs[1] = '{32'd5,   0, 1'b1,  6, 1'b1, 32'd5};
        vecs[2] = '{32'd4,   4, 1'b1,  5, 1'b0, 32'd4};
        vecs[3] = '{32'd1,   0, 1'b0,  2, 1'b1, 32'd1};
        vecs[4] = '{32'd20,  3, 1'b1,  4, 1'b0, 32'd3};
        vecs[5] = '{32'd3,   7, 1'b0,  4, 1'b1, 32'd3};

        bus.go_sync = 1'b0; bus.irq_en = 1'b0; bus.irq_clr = 1'b0;
        bus.timeout = '0;   bus.core_done = 1'b0;

        tick();
        tick();
        check("rst_core_start", 32'(bus.core_start), 32'd0);
        check("rst_busy",       32'(bus.busy),       32'd0);
        check("rst_done",       32'(bus.done),       32'd0);
        check("rst_error",      32'(bus.error),      32'd0);
        check("rst_cycle_count", bus.cycle_count,    32'd0);
        bus.irq_en = 1'b1;
        #1;
        check("rst_irq",        32'(bus.irq),        32'd0);
        reset_n = 1'b1;
        tick();
        tick();

        for (int i = 0; i < 6; i++) begin
            bus.irq_en = vecs[i].irq_en;
            run_op(vecs[i].timeout, vecs[i].dly, 0, starts, busy_n, got);
            check($sformatf("v%0d_starts", i), 32'(starts), 32'd1);
            check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'(vecs[i].exp_busy));
            check($sformatf("v%0d_busy_low", i), 32'(bus.busy), 32'd0);
            check($sformatf("v%0d_error", i), 32'(bus.error), 32'(vecs[i].exp_error));
            check($sformatf("v%0d_cycle_count", i), bus.cycle_count, vecs[i].exp_cc);
            check($sformatf("v%0d_irq", i), 32'(bus.irq), 32'(vecs[i].irq_en));
            finish_op($sformatf("v%0d", i));
        end

        // go held high after a timeout: no restart, done holds, late core_done ignored
        bus.irq_en = 1'b1;
        run_op(32'd5, 0, 0, starts, busy_n, got);
        n_start2 = 0; n_drop = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            bus.core_done = 1'b0;
            if (bus.core_start) n_start2++;
            if (!bus.done || bus.busy) n_drop++;
            if (k == 3) bus.core_done = 1'b1;
        end
        bus.core_done = 1'b0;
        check("held_go_restarts", 32'(n_start2), 32'd0);
        check("held_go_done_lost", 32'(n_drop), 32'd0);
        check("late_done_error", 32'(bus.error), 32'd1);
        check("late_done_cycle_count", bus.cycle_count, 32'd5);
        finish_op("held");

        // irq_clr on the DONE-entry cycle: set wins
        bus.irq_en = 1'b1;
        run_op(32'd4, 0, 4, starts, busy_n, got);
        check("clr_on_entry_irq", 32'(bus.irq), 32'd1);
        tick();
        check("clr_on_entry_irq_hold", 32'(bus.irq), 32'd1);
        finish_op("clr_entry");

        // masked completion, then unmask / toggle / clear
        bus.irq_en = 1'b0;
        run_op(32'd2, 0, 0, starts, busy_n, got);
        tick();
        check("masked_irq", 32'(bus.irq), 32'd0);
        bus.irq_en = 1'b1;
        #1;
        check("unmask_irq", 32'(bus.irq), 32'd1);
        bus.irq_en = 1'b0;
        tick();
        bus.irq_en = 1'b1;
        #1;
        check("toggle_keeps_pend", 32'(bus.irq), 32'd1);
        bus.irq_clr = 1'b1;
        tick();
        bus.irq_clr = 1'b0;
        check("clr_irq", 32'(bus.irq), 32'd0);
        bus.go_sync = 1'b0;
        tick();
        tick();

        // reset in the middle of BUSY, go still high at release
        bus.timeout = '0;
        bus.go_sync = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            if (bus.core_start) got = 1'b1;
        end
        check("mid_reset_started", 32'(got), 32'd1);
        tick();
        tick();
        check("mid_reset_busy_before", 32'(bus.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_reset_busy", 32'(bus.busy), 32'd0);
        check("mid_reset_core_start", 32'(bus.core_start), 32'd0);
        check("mid_reset_done", 32'(bus.done), 32'd0);
        check("mid_reset_error", 32'(bus.error), 32'd0);
        check("mid_reset_cycle_count", bus.cycle_count, 32'd0);
        check("mid_reset_irq", 32'(bus.irq), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check("post_reset_core_start", 32'(bus.core_start), 32'd1);
        check("post_reset_busy", 32'(bus.busy), 32'd1);
        tick();
        check("post_reset_start_pulse", 32'(bus.core_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end
endmodule
